// File: rtl/piggy_pkg.sv
// Shared constants and edge encoding for the piggy input front end.
// Downstream coin logic decodes debounced edges through piggy_edge_e.
package piggy_pkg;

  localparam int PIGGY_N_CH       = 8;
  localparam int PIGGY_SAMPLE_DIV = 1000;
  localparam int PIGGY_STABLE_CNT = 4;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } piggy_edge_e;

  // Counter width that still holds values 0..n-1, never narrower than one bit.
  function automatic int piggy_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic piggy_edge_e piggy_edge_of(input logic rise, input logic fall);
    if (rise)      return EDGE_RISE;
    else if (fall) return EDGE_FALL;
    else           return EDGE_NONE;
  endfunction

endpackage

// File: rtl/piggy_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous button/coin inputs.
module piggy_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/piggy_deb_scheduler.sv
// Time-multiplexed debouncer: one prescaler and one round-robin pointer serve all
// channels; each slot evaluates a single channel through one shared comparator.
module piggy_deb_scheduler
  import piggy_pkg::*;
#(
  parameter int N_CH       = PIGGY_N_CH,
  parameter int SAMPLE_DIV = PIGGY_SAMPLE_DIV,
  parameter int STABLE_CNT = PIGGY_STABLE_CNT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         raw_in,
  input  logic                    scan_en,
  input  logic [N_CH-1:0]         ch_mask,
  output logic [N_CH-1:0]         db_out,
  output logic [N_CH-1:0]         rise_pulse,
  output logic [N_CH-1:0]         fall_pulse,
  output logic                    slot_valid,
  output logic [$clog2(N_CH)-1:0] slot_ch
);

  localparam int PTR_W = $clog2(N_CH);
  localparam int PRE_W = piggy_w(SAMPLE_DIV);
  localparam int CNT_W = piggy_w(STABLE_CNT);

  localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(SAMPLE_DIV - 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(STABLE_CNT - 1);

  logic [N_CH-1:0]             w_sync;
  logic [PRE_W-1:0]            r_pre;
  logic [PTR_W-1:0]            r_ptr;
  logic [N_CH-1:0][CNT_W-1:0]  r_cnt;
  logic [N_CH-1:0]             r_db;
  logic [N_CH-1:0]             r_rise;
  logic [N_CH-1:0]             r_fall;
  logic                        r_slot_valid;
  logic [PTR_W-1:0]            r_slot_ch;

  logic                        w_tick;
  logic                        w_svc;
  logic                        w_sel_sync;
  logic                        w_sel_db;
  logic [CNT_W-1:0]            w_sel_cnt;
  logic                        w_differ;
  logic                        w_at_limit;
  logic                        w_flip;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic [PTR_W-1:0]            w_ptr_nxt;
  logic [PRE_W-1:0]            w_pre_nxt;

  piggy_sync2 #(.W(N_CH)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (raw_in),
    .o_q (w_sync)
  );

  // Single mux on the slot pointer feeds the shared compare/increment path.
  assign w_sel_sync = w_sync[r_ptr];
  assign w_sel_db   = r_db[r_ptr];
  assign w_sel_cnt  = r_cnt[r_ptr];

  assign w_tick     = scan_en & (r_pre == '0);
  assign w_svc      = w_tick & ch_mask[r_ptr];
  assign w_differ   = w_sel_sync ^ w_sel_db;
  assign w_at_limit = (w_sel_cnt == CNT_LIMIT);
  assign w_flip     = w_svc & w_differ & w_at_limit;
  assign w_cnt_nxt  = (w_differ & ~w_at_limit) ? (w_sel_cnt + CNT_W'(1)) : '0;
  assign w_ptr_nxt  = (r_ptr == PTR_LAST) ? '0 : (r_ptr + PTR_W'(1));
  assign w_pre_nxt  = w_tick ? PRE_RELOAD : (r_pre - PRE_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre        <= PRE_RELOAD;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_db         <= '0;
      r_rise       <= '0;
      r_fall       <= '0;
      r_slot_valid <= 1'b0;
      r_slot_ch    <= '0;
    end else begin
      r_rise       <= '0;
      r_fall       <= '0;
      r_slot_valid <= w_tick;
      if (scan_en) begin
        r_pre <= w_pre_nxt;
      end
      // A masked slot still advances the pointer so the revisit period never changes.
      if (w_tick) begin
        r_ptr     <= w_ptr_nxt;
        r_slot_ch <= r_ptr;
      end
      if (w_svc) begin
        r_cnt[r_ptr] <= w_cnt_nxt;
        if (w_flip) begin
          r_db[r_ptr]   <= ~w_sel_db;
          r_rise[r_ptr] <= ~w_sel_db;
          r_fall[r_ptr] <= w_sel_db;
        end
      end
    end
  end

  assign db_out     = r_db;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign slot_valid = r_slot_valid;
  assign slot_ch    = r_slot_ch;

endmodule

// File: tb/tb_piggy_deb_scheduler.sv
// Scoreboarded bench for piggy_deb_scheduler with N_CH=4, SAMPLE_DIV=4, STABLE_CNT=3.
module tb_piggy_deb_scheduler;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int STB = 3;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw_in = 4'h0;
  logic       scan_en = 1'b1;
  logic [3:0] ch_mask = 4'hF;
  logic [3:0] db_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic       slot_valid;
  logic [1:0] slot_ch;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  exp_t sb_q[$];
  exp_t m_push;
  exp_t m_pop;
  logic exp_sv;
  int   m_pre;
  int   m_ptr;
  int   m_cnt[4];
  logic [3:0] m_db;
  logic [3:0] m_s1;
  logic [3:0] m_s2;

  always #5 clk = ~clk;

  piggy_deb_scheduler #(
    .N_CH       (N),
    .SAMPLE_DIV (DIV),
    .STABLE_CNT (STB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .scan_en    (scan_en),
    .ch_mask    (ch_mask),
    .db_out     (db_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .slot_valid (slot_valid),
    .slot_ch    (slot_ch)
  );

  // Reference model: pushes the strobe it expects on every tick edge.
  always @(posedge clk) begin
    if (rst) begin
      m_pre = DIV - 1;
      m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_db = 4'h0;
      m_s1 = 4'h0;
      m_s2 = 4'h0;
      sb_q.delete();
    end else begin
      if (scan_en && m_pre == 0) begin
        m_push.ch   = m_ptr[1:0];
        m_push.rise = 4'h0;
        m_push.fall = 4'h0;
        if (ch_mask[m_ptr]) begin
          if (m_s2[m_ptr] == m_db[m_ptr]) m_cnt[m_ptr] = 0;
          else if (m_cnt[m_ptr] < STB - 1) m_cnt[m_ptr] = m_cnt[m_ptr] + 1;
          else begin
            m_cnt[m_ptr] = 0;
            if (m_db[m_ptr]) m_push.fall[m_ptr] = 1'b1;
            else             m_push.rise[m_ptr] = 1'b1;
            m_db[m_ptr] = ~m_db[m_ptr];
          end
        end
        m_push.db = m_db;
        sb_q.push_back(m_push);
        m_pre = DIV - 1;
        m_ptr = (m_ptr + 1) % N;
      end else if (scan_en) begin
        m_pre = m_pre - 1;
      end
      m_s2 = m_s1;
      m_s1 = raw_in;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      exp_sv = (sb_q.size() != 0);
      n_checks++;
      if (slot_valid !== exp_sv)
        $display("FAIL sb_strobe: slot_valid=%b expected %b at %0t", slot_valid, exp_sv, $time);
      else n_pass++;
      if (exp_sv) begin
        m_pop = sb_q.pop_front();
        n_checks++;
        if ({slot_ch, db_out, rise_pulse, fall_pulse} !== {m_pop.ch, m_pop.db, m_pop.rise, m_pop.fall})
          $display("FAIL sb_slot: ch/db/rise/fall=%0d/%h/%h/%h expected %0d/%h/%h/%h at %0t",
                   slot_ch, db_out, rise_pulse, fall_pulse, m_pop.ch, m_pop.db, m_pop.rise, m_pop.fall, $time);
        else n_pass++;
      end else begin
        n_checks++;
        if ({db_out, rise_pulse, fall_pulse} !== {m_db, 8'h00})
          $display("FAIL sb_idle: db/rise/fall=%h/%h/%h expected %h/0/0 at %0t",
                   db_out, rise_pulse, fall_pulse, m_db, $time);
        else n_pass++;
      end
    end
  end

  // Waits for a slot strobe (ch<0 matches any channel); cycles=-1 on timeout.
  task automatic wait_slot(input int ch, input int bound, output int cycles);
    cycles = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (slot_valid && (ch < 0 || slot_ch == ch[1:0])) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int seq[5];
    int cyc;
    seq = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    n_checks++;
    if ({db_out, rise_pulse, fall_pulse, slot_valid, slot_ch} !== 15'h0)
      $display("FAIL reset_state: outputs=%h expected 0", {db_out, rise_pulse, fall_pulse, slot_valid, slot_ch});
    else n_pass++;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_slot(-1, 10, cyc);
      n_checks++;
      if (cyc != 4 || slot_ch !== seq[k][1:0])
        $display("FAIL slot_seq%0d: gap=%0d ch=%0d expected gap 4 ch %0d", k, cyc, slot_ch, seq[k]);
      else n_pass++;
    end
  endtask

  task automatic test_steady_rise;
    int nrise;
    int nfall;
    logic [3:0] rval;
    nrise = 0;
    nfall = 0;
    rval  = 4'h0;
    raw_in[2] = 1'b1;
    for (int i = 0; i < 2 + STB * N * DIV + 1; i++) begin
      @(negedge clk);
      if (|rise_pulse) begin
        nrise++;
        rval = rise_pulse;
      end
      if (|fall_pulse) nfall++;
    end
    n_checks++;
    if (db_out[2] !== 1'b1) $display("FAIL rise_db2: db_out=%h expected bit2 set", db_out);
    else n_pass++;
    n_checks++;
    if (nrise != 1 || rval !== 4'b0100 || nfall != 0)
      $display("FAIL rise_pulses: nrise=%0d val=%b nfall=%0d expected 1/0100/0", nrise, rval, nfall);
    else n_pass++;
  endtask

  task automatic test_glitch;
    int cyc;
    wait_slot(1, 40, cyc);
    n_checks++;
    if (cyc < 0) $display("FAIL glitch_wait: no ch1 slot got %0d expected >0", cyc);
    else n_pass++;
    raw_in[1] = 1'b1;
    repeat (32) @(negedge clk);
    n_checks++;
    if (dut.r_cnt[1] !== 2'd2 || db_out[1] !== 1'b0)
      $display("FAIL glitch_mid: cnt1=%0d db1=%b expected 2/0", dut.r_cnt[1], db_out[1]);
    else n_pass++;
    repeat (4) @(negedge clk);
    raw_in[1] = 1'b0;
    repeat (32) @(negedge clk);
    n_checks++;
    if (dut.r_cnt[1] !== 2'd0 || db_out[1] !== 1'b0)
      $display("FAIL glitch_end: cnt1=%0d db1=%b expected 0/0", dut.r_cnt[1], db_out[1]);
    else n_pass++;
  endtask

  task automatic test_mask;
    int cyc;
    int gap;
    int k;
    ch_mask   = 4'b1110;
    raw_in[0] = 1'b1;
    wait_slot(0, 40, cyc);
    n_checks++;
    if (cyc < 0) $display("FAIL mask_wait: no ch0 slot got %0d expected >0", cyc);
    else n_pass++;
    gap = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      gap++;
      if (slot_valid) begin
        n_checks++;
        if (gap != 4) $display("FAIL mask_gap: gap=%0d expected 4", gap);
        else n_pass++;
        gap = 0;
      end
    end
    n_checks++;
    if (db_out[0] !== 1'b0 || dut.r_cnt[0] !== 2'd0)
      $display("FAIL mask_hold: db0=%b cnt0=%0d expected 0/0", db_out[0], dut.r_cnt[0]);
    else n_pass++;
    ch_mask = 4'hF;
    k = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (slot_valid && slot_ch == 2'd0) begin
        k++;
        n_checks++;
        if (rise_pulse !== ((k == 3) ? 4'b0001 : 4'b0000) || db_out[0] !== (k == 3))
          $display("FAIL unmask_ch0_sample%0d: rise=%b db0=%b expected %b/%b",
                   k, rise_pulse, db_out[0], (k == 3) ? 4'b0001 : 4'b0000, (k == 3));
        else n_pass++;
      end
    end
    n_checks++;
    if (k != 3) $display("FAIL unmask_samples: got %0d expected 3", k);
    else n_pass++;
  endtask

  task automatic test_freeze;
    int cyc;
    int found;
    found = 0;
    raw_in[3] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (slot_valid && slot_ch == 2'd3 && dut.r_cnt[3] == 2'd1) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (found == 0) $display("FAIL freeze_wait: cnt3 never reached 1, got %0d expected 1", found);
    else n_pass++;
    scan_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (slot_valid !== 1'b0 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0)
        $display("FAIL freeze_quiet: sv=%b rise=%h fall=%h expected 0/0/0", slot_valid, rise_pulse, fall_pulse);
      else n_pass++;
    end
    n_checks++;
    if (dut.r_pre !== 2'd3 || dut.r_ptr !== 2'd0 || dut.r_cnt[3] !== 2'd1 || db_out[3] !== 1'b0)
      $display("FAIL freeze_hold: pre=%0d ptr=%0d cnt3=%0d db3=%b expected 3/0/1/0",
               dut.r_pre, dut.r_ptr, dut.r_cnt[3], db_out[3]);
    else n_pass++;
    scan_en = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (rise_pulse[3]) begin
        cyc = i;
        break;
      end
    end
    n_checks++;
    if (cyc != 32) $display("FAIL freeze_resume_latency: got %0d expected 32", cyc);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int found;
    int cyc;
    raw_in = 4'hF;
    found = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (db_out === 4'hF) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (found == 0) $display("FAIL rstmid_allhigh: db_out=%h expected f", db_out);
    else n_pass++;
    raw_in = 4'h0;
    found = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (dut.r_pre == 2'd0 && dut.r_cnt[dut.r_ptr] == 2'd2 && db_out[dut.r_ptr] == 1'b1) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (found == 0) $display("FAIL rstmid_due: no pending fall found, got %0d expected 1", found);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({db_out, rise_pulse, fall_pulse, slot_valid, slot_ch} !== 15'h0)
      $display("FAIL rstmid_outputs: outputs=%h expected 0", {db_out, rise_pulse, fall_pulse, slot_valid, slot_ch});
    else n_pass++;
    n_checks++;
    if (dut.r_ptr !== 2'd0 || dut.r_pre !== 2'd3 || dut.r_cnt !== 8'h00)
      $display("FAIL rstmid_regs: ptr=%0d pre=%0d cnt=%h expected 0/3/00", dut.r_ptr, dut.r_pre, dut.r_cnt);
    else n_pass++;
    rst = 1'b0;
    wait_slot(-1, 10, cyc);
    n_checks++;
    if (cyc != 4 || slot_ch !== 2'd0)
      $display("FAIL rstmid_restart: gap=%0d ch=%0d expected 4/0", cyc, slot_ch);
    else n_pass++;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_steady_rise();
    test_glitch();
    test_mask();
    test_freeze();
    test_reset_mid();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
